// File: rtl/sum_uart_pkg.sv
// sum_uart_pkg
// Shared definitions for the sum-to-UART transmitter: FSM state encoding,
// 8N1 frame geometry and serial line levels.
package sum_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/sum_uart_baud.sv
// sum_uart_baud
// Bit-period timer for the UART transmitter. Counts 0..CLKS_PER_BIT-1 and
// wraps, flagging the last cycle of every bit period.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   clear_i   in   holds the count at zero (asserted while the line is idle)
//   bit_end_o out  high in the final cycle of the current bit period
module sum_uart_baud #(
  parameter int CLKS_PER_BIT = 1042
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic bit_end_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign bit_end_o = !clear_i && (cnt_q == LAST_CNT);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear_i || bit_end_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sum_uart_tx.sv
// sum_uart_tx
// Latches the adder sum on a load strobe and sends it as one 8N1 UART frame
// (start bit, 8 data bits LSB first, stop bit). The latched sum is also
// presented in parallel for display.
//
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset
//   sum_in  in   adder sum, zero-extended to 8 data bits when captured
//   load    in   latch-and-send strobe, accepted only while idle
//   tx      out  serial line, idle high
//   busy    out  high while a frame is in flight
//   done    out  one-cycle pulse in the first idle cycle after the stop bit
//   drop    out  one-cycle pulse for each load cycle rejected while busy
//   sum_q   out  last accepted sum
module sum_uart_tx
  import sum_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1042,
  parameter int SUM_W        = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SUM_W-1:0] sum_in,
  input  logic             load,
  output logic             tx,
  output logic             busy,
  output logic             done,
  output logic             drop,
  output logic [SUM_W-1:0] sum_q
);

  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

  uart_state_e               state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [SUM_W-1:0]          sum_lat_q, sum_lat_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      drop_q, drop_d;
  logic [UART_DATA_BITS-1:0] sum_ext;
  logic                      bit_end;

  sum_uart_baud #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (state_q == IDLE),
    .bit_end_o(bit_end)
  );

  always_comb begin
    sum_ext              = '0;
    sum_ext[SUM_W-1:0]   = sum_in;
  end

  // tx and busy are derived from the next state so they change on the same
  // edge as the state, keeping the line glitch-free and frame timing exact.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    sum_lat_d = sum_lat_q;
    done_d    = 1'b0;
    drop_d    = load && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (load) begin
          sum_lat_d = sum_in;
          shift_d   = sum_ext;
          idx_d     = '0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = LINE_START;
      DATA:    tx_d = shift_d[0];
      STOP:    tx_d = LINE_STOP;
      default: tx_d = LINE_IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      idx_q     <= '0;
      sum_lat_q <= '0;
      tx_q      <= LINE_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      sum_lat_q <= sum_lat_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      drop_q    <= drop_d;
    end
  end

  assign tx    = tx_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign drop  = drop_q;
  assign sum_q = sum_lat_q;

endmodule
